// File: rtl/serial_pattern_tx_if.sv
// Host-to-transmitter request channel plus the serial output and status lines.
//   start_valid/start_ready : request handshake (host -> block)
//   pattern                 : WIDTH-bit frame, MSB sent first
//   rep                     : extra repetitions (transmissions = rep+1)
//   w                       : serial data bit
//   busy / done             : transmission in progress / one-cycle end pulse
interface serial_pattern_tx_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned REPEAT_W = 4
);
  logic                start_valid;
  logic                start_ready;
  logic [WIDTH-1:0]    pattern;
  logic [REPEAT_W-1:0] rep;
  logic                w;
  logic                busy;
  logic                done;

  // Host side
  modport master (
    output start_valid, pattern, rep,
    input  start_ready, w, busy, done
  );

  // Transmitter side
  modport slave (
    input  start_valid, pattern, rep,
    output start_ready, w, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern + repeat count on a valid/ready
// handshake and shifts the pattern out MSB-first on w, inserting GAP_CYCLES
// zero bits between repetitions, then pulses done for one cycle.
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset
//   bus   : serial_pattern_tx_if.slave (handshake, pattern, rep, w, busy, done)
module serial_pattern_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned REPEAT_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  serial_pattern_tx_if.slave    bus
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q,  state_d;
  logic [WIDTH-1:0]    pat_q,    pat_d;
  logic [WIDTH-1:0]    shreg_q,  shreg_d;
  logic [REPEAT_W-1:0] reps_q,   reps_d;
  logic [BW-1:0]       bitcnt_q, bitcnt_d;
  logic [GW-1:0]       gapcnt_q, gapcnt_d;
  logic                w_q,      w_d;
  logic                busy_q,   busy_d;
  logic                ready_q,  ready_d;
  logic                done_q,   done_d;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      shreg_q  <= '0;
      reps_q   <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      w_q      <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      shreg_q  <= shreg_d;
      reps_q   <= reps_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      w_q      <= w_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    shreg_d  = shreg_q;
    reps_d   = reps_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;

    unique case (state_q)
      S_IDLE: begin
        // ready_q mirrors state==IDLE, so this is the accept condition
        if (bus.start_valid && ready_q) begin
          pat_d    = bus.pattern;
          shreg_d  = bus.pattern;
          reps_d   = bus.rep;
          bitcnt_d = BIT_LAST;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q - BW'(1);
        if (bitcnt_q == '0) begin
          if (reps_q == '0) begin
            state_d = S_DONE;
          end else begin
            reps_d   = reps_q - REPEAT_W'(1);
            shreg_d  = pat_q;
            bitcnt_d = BIT_LAST;
            if (GAP_CYCLES > 0) begin
              gapcnt_d = GAP_LAST;
              state_d  = S_GAP;
            end else begin
              state_d  = S_SHIFT;
            end
          end
        end
      end
      S_GAP: begin
        gapcnt_d = gapcnt_q - GW'(1);
        if (gapcnt_q == '0) begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of the decode of the next state
    w_d     = (state_d == S_SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  assign bus.w           = w_q;
  assign bus.busy        = busy_q;
  assign bus.start_ready = ready_q;
  assign bus.done        = done_q;

endmodule
